// File: rtl/backing_mem.sv
// Byte-wide 64-entry main-memory model behind the cache, with a fixed access latency,
// single-outstanding request/ready handshake and saturating access counters.
module backing_mem #(
   parameter int unsigned LATENCY = 4
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       MemReq,
   input  logic       MemRWB,
   input  logic [5:0] MemAddr,
   input  logic [7:0] MemWData,
   output logic [7:0] MemRData,
   output logic       MemReady,
   output logic       MemBusy,
   output logic [7:0] ReadCount,
   output logic [7:0] WriteCount
);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        rwb_q, rwb_d;
   logic [5:0]  addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [7:0]  rdata_q, rdata_d;
   logic [7:0]  rd_cnt_q, rd_cnt_d;
   logic [7:0]  wr_cnt_q, wr_cnt_d;
   logic        mem_we;
   logic [7:0]  mem_q [64];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rwb_d    = rwb_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      rd_cnt_d = rd_cnt_q;
      wr_cnt_d = wr_cnt_q;
      mem_we   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (MemReq) begin
               rwb_d   = MemRWB;
               addr_d  = MemAddr;
               wdata_d = MemWData;
               cnt_d   = 4'(LATENCY - 1);
               state_d = StBusy;
            end
         end
         StBusy: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = StDone;
               if (rwb_q) begin
                  rdata_d = mem_q[addr_q];
                  if (rd_cnt_q != 8'hFF) rd_cnt_d = rd_cnt_q + 8'd1;
               end else begin
                  mem_we = 1'b1;
                  if (wr_cnt_q != 8'hFF) wr_cnt_d = wr_cnt_q + 8'd1;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q  <= StIdle;
         cnt_q    <= 4'd0;
         rwb_q    <= 1'b1;
         addr_q   <= 6'd0;
         wdata_q  <= 8'd0;
         rdata_q  <= 8'd0;
         rd_cnt_q <= 8'd0;
         wr_cnt_q <= 8'd0;
         // Identity pattern gives benches a known value at every address.
         for (int i = 0; i < 64; i++) begin
            mem_q[i] <= 8'(i);
         end
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rwb_q    <= rwb_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
         if (mem_we) mem_q[addr_q] <= wdata_q;
      end
   end

   // Outputs are decodes of registered state only; no input reaches them combinationally.
   assign MemRData   = rdata_q;
   assign MemReady   = (state_q == StDone);
   assign MemBusy    = (state_q != StIdle);
   assign ReadCount  = rd_cnt_q;
   assign WriteCount = wr_cnt_q;

endmodule

// File: doc/backing_mem.md
# backing_mem

Byte-wide main-memory model with a configurable access latency. It sits directly downstream of the two-way set-associative cache inside the memory system and services the cache's miss fills and write traffic over a single-outstanding request/ready handshake. It holds the full 64-byte address space and keeps saturating read and write access counters so that benches can check miss traffic against hit counts.

## Interface
Parameters:
- LATENCY, default 4: clock edges from request acceptance to completion; legal range 1..15.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-low reset.
- MemReq  in  1  request strobe from the cache; sampled only in IDLE.
- MemRWB  in  1  1 = read, 0 = write (same polarity as the core RWB).
- MemAddr  in  6  byte address.
- MemWData  in  8  write data.
- MemRData  out  8  read data; updated only when a read completes; otherwise held.
- MemReady  out  1  one-cycle completion pulse.
- MemBusy  out  1  high in BUSY and DONE.
- ReadCount  out  8  completed reads; saturates at 255.
- WriteCount  out  8  completed writes; saturates at 255.

## Operation
- Storage is 64 x 8 registers.
- On Reset=0 at an edge:
  - mem[i] = i for all i (a known pattern for benches).
  - State goes to IDLE.
  - MemRData = 0, MemReady = 0, MemBusy = 0, ReadCount = 0, WriteCount = 0.
- FSM states are IDLE, BUSY and DONE. Reset overrides every transition.
- IDLE:
  - If MemReq=1, latch MemRWB, MemAddr and MemWData.
  - Load Cnt = LATENCY-1 (4-bit counter) and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - If Cnt != 0, decrement Cnt.
  - If Cnt == 0, complete the access, set MemReady = 1 and go to DONE.
  - For a write, mem[latched addr] = latched data and WriteCount increments.
  - For a read, MemRData = mem[latched addr] and ReadCount increments.
  - Increments saturate at 255 (8'hFF + 1 stays 8'hFF).
- DONE:
  - MemReady = 1 for this cycle only.
  - Next state is always IDLE. MemReq is ignored in DONE.
- Inputs that change during BUSY or DONE are ignored. Only the values latched at acceptance are used.
- A read of an address returns the value of the most recently completed write to it.
- There is only ever one transaction in flight. No queueing, no error responses, and every address is valid.

## Timing
- Request accepted at edge E0 (in IDLE with MemReq=1): MemBusy rises after E0, and completion happens at edge E0+LATENCY.
- MemReady and new MemRData are visible after E0+LATENCY and last for exactly one cycle (the DONE cycle).
- MemReady falls after edge E0+LATENCY+1, which is also when the block returns to IDLE and MemBusy falls.
- Requester rule: MemReq stays high until MemReady is seen. The requester then drops MemReq in the following (IDLE) cycle unless it is issuing a new request.
- There is no combinational path from any input to any output. All outputs are registered.
- If MemReq is held high continuously, a new transaction is accepted every LATENCY+2 edges.
- With LATENCY=1: accept at E0, MemReady after E0+1.
- Reset during BUSY or DONE aborts the transaction:
  - A pending write is not performed.
  - No MemReady is produced.
  - Memory is reinitialised to mem[i] = i.
- MemRData retains the last read value through any number of writes; only Reset clears it.

## Test plan
- Reset, then read address 6'd37 (LATENCY=4) -> MemReady pulses one cycle after edge E0+4, MemRData=8'd37, ReadCount=1, WriteCount=0, MemBusy high for 5 cycles.
- Write 8'hC3 to 6'd10, then read 6'd10 -> read returns 8'hC3, WriteCount=1, ReadCount=1; MemRData stays 8'hC3 through a subsequent write of 8'h00 to 6'd11.
- Accept a read of 6'd3, then drive MemAddr=6'd60 and MemRWB=0 during BUSY -> MemRData=8'd3, mem[60] still reads 8'd60, WriteCount unchanged.
- Write 8'hFF to 6'd5 and assert Reset in the second BUSY cycle -> no MemReady pulse; after Reset, a read of 6'd5 returns 8'd5 and both counters read 1/0 (read only).
- Hold MemReq=1, MemRWB=1 for 300 transactions -> acceptances are exactly LATENCY+2 edges apart; ReadCount reaches 255 and stays at 255.
- LATENCY=1 instance: read 6'd63 -> MemReady after E0+1 with MemRData=8'd63; no acceptance occurs in the DONE cycle.
